// File: rtl/piso_pkg.sv
// Shared types and width helpers for the piso_tx serial transmitter.
// Optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_pkg;

    // Transmit sequencer states; PAR is only entered with parity enabled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

`ifdef PISO_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Width of the clock-divider counter (0 .. DIV-1).
    function automatic int divcnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Width of the bit counter (0 .. DEPTH).
    function automatic int bitcnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period timer: counts DIV clocks per serial bit and flags the
// first (o_bit_start) and last (o_bit_end) cycle of each period.
// Ports: i_clk, i_rst_n (sync, active-low), i_clear, i_run,
//        o_bit_start, o_bit_end.
module piso_bit_timer
    import piso_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_bit_start,
    output logic o_bit_end
);

    localparam int DCW = divcnt_w(DIV);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    logic [DCW-1:0] r_divcnt;
    logic           w_end;

    // With DIV=1 the counter is pinned at 0, so start and end coincide.
    assign w_end = (r_divcnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_divcnt <= '0;
        end else if (i_clear) begin
            r_divcnt <= '0;
        end else if (i_run) begin
            r_divcnt <= w_end ? '0 : r_divcnt + DCW'(1);
        end
    end

    assign o_bit_start = i_run & (r_divcnt == '0);
    assign o_bit_end   = i_run & w_end;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a DEPTH-bit word over a
// valid/ready handshake and sends it LSB-first, DIV clocks per bit.
// Ports: clk, rst_n (sync, active-low), din/din_valid/din_ready (input
//        handshake), sdo/sdo_en (serial data + per-bit strobe),
//        busy (transfer active), done (one-cycle end-of-word pulse).
// Macro PISO_TX_PARITY_EN appends an even-parity bit period.
module piso_tx
    import piso_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_en,
    output logic             busy,
    output logic             done
);

    localparam int BCW = bitcnt_w(DEPTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DEPTH - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [DEPTH-1:0] r_shreg;
    logic [DEPTH-1:0] w_nxt_shreg;
    logic [BCW-1:0]   r_bitcnt;
    logic [BCW-1:0]   w_nxt_bitcnt;
    logic             r_sdo;
    logic             r_sdo_en;
    logic             r_busy;
    logic             r_done;
    logic             w_nxt_sdo;
    logic             w_nxt_sdo_en;
    logic             w_nxt_done;
    logic             w_accept;
    logic             w_run;
    logic             w_bit_start;
    logic             w_bit_end;
    logic             w_last_bit;
    logic             w_par_bit;

`ifdef PISO_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^din;
        end
    end

    assign w_par_bit = r_par;
`else
    assign w_par_bit = 1'b0;
`endif

    assign din_ready = (r_state == IDLE) & rst_n;
    assign w_accept  = din_valid & din_ready;
    assign w_run     = (r_state != IDLE);

    piso_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (w_accept),
        .i_run      (w_run),
        .o_bit_start(w_bit_start),
        .o_bit_end  (w_bit_end)
    );

    assign w_last_bit = (r_state == SHIFT) & w_bit_end &
                        (r_bitcnt == BIT_LAST);

    // The shifter drops the current bit as its period begins, so at the
    // period end the next bit to send already sits in w_nxt_shreg[0].
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_shreg  = r_shreg;
        w_nxt_bitcnt = r_bitcnt;
        w_nxt_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_state  = SHIFT;
                    w_nxt_shreg  = din;
                    w_nxt_bitcnt = '0;
                end
            end
            SHIFT: begin
                if (w_bit_start) begin
                    w_nxt_shreg = r_shreg >> 1;
                end
                if (w_bit_end) begin
                    if (r_bitcnt == BIT_LAST) begin
                        w_nxt_bitcnt = '0;
                        if (PARITY_EN) begin
                            w_nxt_state = PAR;
                        end else begin
                            w_nxt_state = IDLE;
                            w_nxt_done  = 1'b1;
                        end
                    end else begin
                        w_nxt_bitcnt = r_bitcnt + BCW'(1);
                    end
                end
            end
            PAR: begin
                if (w_bit_end) begin
                    w_nxt_state = IDLE;
                    w_nxt_done  = 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Registered outputs are loaded with the values of the coming cycle.
    always_comb begin
        w_nxt_sdo = r_sdo;
        if (w_accept) begin
            w_nxt_sdo = din[0];
        end else if (w_last_bit) begin
            w_nxt_sdo = PARITY_EN ? w_par_bit : 1'b0;
        end else if (w_bit_end) begin
            w_nxt_sdo = (r_state == SHIFT) ? w_nxt_shreg[0] : 1'b0;
        end
    end

    assign w_nxt_sdo_en = w_accept | (w_bit_end & (w_nxt_state != IDLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_sdo    <= 1'b0;
            r_sdo_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_shreg  <= w_nxt_shreg;
            r_bitcnt <= w_nxt_bitcnt;
            r_sdo    <= w_nxt_sdo;
            r_sdo_en <= w_nxt_sdo_en;
            r_busy   <= (w_nxt_state != IDLE);
            r_done   <= w_nxt_done;
        end
    end

    assign sdo    = r_sdo;
    assign sdo_en = r_sdo_en;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Randomized bench for piso_tx, DIV=1 and DIV=3 instances on shared
// stimulus, each checked against a per-word expected waveform queue.
module tb_piso_tx;

    localparam int DEPTH = 4;

    typedef logic [3:0] ent_t;
    typedef ent_t ent_q_t[$];

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din_valid;
    logic [DEPTH-1:0] din;

    logic rdy1, sdo1, en1, busy1, done1;
    logic rdy3, sdo3, en3, busy3, done3;

    always #5 clk = ~clk;

    piso_tx #(.DEPTH(DEPTH), .DIV(1)) u_d1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(rdy1),
        .sdo      (sdo1),
        .sdo_en   (en1),
        .busy     (busy1),
        .done     (done1)
    );

    piso_tx #(.DEPTH(DEPTH), .DIV(3)) u_d3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(rdy3),
        .sdo      (sdo3),
        .sdo_en   (en3),
        .busy     (busy3),
        .done     (done3)
    );

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     chk_on = 1'b0;
    ent_q_t q1, q3;
    ent_t   e1, e3;
    logic   er1 = 1'b0;
    logic   er3 = 1'b0;

    // Expected {sdo, sdo_en, busy, done} for every cycle of one word,
    // starting the cycle after acceptance and ending with the done cycle.
    function automatic ent_q_t build(input logic [DEPTH-1:0] w,
                                     input int div);
        ent_q_t       q;
        logic [DEPTH:0] bits;
        int           nb;
        bits = {^w, w};
`ifdef PISO_TX_PARITY_EN
        nb = DEPTH + 1;
`else
        nb = DEPTH;
`endif
        for (int b = 0; b < nb; b++)
            for (int k = 0; k < div; k++)
                q.push_back({bits[b], (k == 0), 1'b1, 1'b0});
        q.push_back(4'b0001);
        return q;
    endfunction

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    // Compare this cycle, then decide what the coming edge does.
    always @(negedge clk) begin
        cyc++;
        if (chk_on) begin
            e1  = (q1.size() > 0) ? q1.pop_front() : 4'b0000;
            e3  = (q3.size() > 0) ? q3.pop_front() : 4'b0000;
            er1 = ~e1[1] & rst_n;
            er3 = ~e3[1] & rst_n;
            check("d1_out", {sdo1, en1, busy1, done1}, e1);
            check("d1_rdy", {3'b000, rdy1}, {3'b000, er1});
            check("d3_out", {sdo3, en3, busy3, done3}, e3);
            check("d3_rdy", {3'b000, rdy3}, {3'b000, er3});
            if (!rst_n) begin
                q1.delete();
                q3.delete();
            end else if (din_valid) begin
                if (er1) q1 = build(din, 1);
                if (er3) q3 = build(din, 3);
            end
        end
    end

    task automatic step(input logic v, input logic [DEPTH-1:0] d,
                        input logic r);
        @(posedge clk);
        #2;
        din_valid = v;
        din       = d;
        rst_n     = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DEPTH'($urandom), 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = DEPTH'($urandom);
        @(posedge clk);
        #2;
        chk_on = 1'b1;
        step(1'b1, DEPTH'($urandom), 1'b0);
        step(1'b1, DEPTH'($urandom), 1'b0);
        idle(2);

        step(1'b1, 4'b1011, 1'b1);
        idle(20);
        step(1'b1, 4'b0011, 1'b1);
        idle(20);
        step(1'b1, 4'b0110, 1'b1);
        idle(20);

        step(1'b1, 4'hA, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 4'h5, 1'b1);
        idle(20);

        step(1'b1, 4'h3, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        idle(20);

        step(1'b1, 4'hC, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b0);
        idle(3);
        step(1'b1, 4'h9, 1'b1);
        idle(20);

        for (int i = 0; i < 400; i++)
            step((($urandom % 3) == 0), DEPTH'($urandom),
                 (($urandom % 50) != 0));
        idle(20);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
